// File: rtl/sgen_fcw_sweep.sv
// FCW sweep sequencer feeding the sgen_nco phase accumulator (linear chirp / sawtooth sweeps).
// Optional triangular sweep: define SGEN_FCW_SWEEP_BOUNCE_EN.
module sgen_fcw_sweep #(
    parameter int gp_phase_accu_width = 16,
    parameter int gp_dwell_width      = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_ena,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic                           i_cont,
    input  logic [gp_phase_accu_width-1:0] i_fcw_start,
    input  logic [gp_phase_accu_width-1:0] i_fcw_stop,
    input  logic [gp_phase_accu_width-1:0] i_fcw_step,
    input  logic [gp_dwell_width-1:0]      i_dwell,
    output logic [gp_phase_accu_width-1:0] o_fcw,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [1:0]                     o_state
);
    localparam int W = gp_phase_accu_width;

    // i_start / i_abort are single-cycle requests with no ready: start is taken only in
    // IDLE/DONE, abort is taken in any state and wins over a simultaneous start.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DN   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                state;
    logic                  cfg_cont;
    logic [W-1:0]          cfg_start;
    logic [W-1:0]          cfg_stop;
    logic [W-1:0]          cfg_step;
    logic [gp_dwell_width-1:0] cfg_dwell;
    logic [gp_dwell_width-1:0] dwell_cnt;

    // One extra bit so a step past the top of the range clamps instead of wrapping.
    logic [W:0] up_next;
    logic       up_clamp;
    assign up_next  = {1'b0, o_fcw} + {1'b0, cfg_step};
    assign up_clamp = (up_next >= {1'b0, cfg_stop});

`ifdef SGEN_FCW_SWEEP_BOUNCE_EN
    logic [W:0] dn_next;
    logic       dn_clamp;
    assign dn_next  = {1'b0, o_fcw} - {1'b0, cfg_step};
    assign dn_clamp = dn_next[W] || (dn_next[W-1:0] <= cfg_start);
`endif

    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state     <= ST_IDLE;
            o_fcw     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            dwell_cnt <= '0;
            cfg_cont  <= 1'b0;
            cfg_start <= '0;
            cfg_stop  <= '0;
            cfg_step  <= '0;
            cfg_dwell <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_abort) begin
                state  <= ST_IDLE;
                o_fcw  <= '0;
                o_busy <= 1'b0;
            end else if (i_start && (state == ST_IDLE || state == ST_DONE)) begin
                cfg_cont  <= i_cont;
                cfg_start <= i_fcw_start;
                cfg_stop  <= i_fcw_stop;
                cfg_step  <= (i_fcw_step == '0) ? {{(W-1){1'b0}}, 1'b1} : i_fcw_step;
                cfg_dwell <= i_dwell;
                o_fcw     <= i_fcw_start;
                dwell_cnt <= i_dwell;
                o_busy    <= 1'b1;
                state     <= ST_UP;
            end else if (i_ena) begin
                case (state)
                    ST_UP: begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end else begin
                            dwell_cnt <= cfg_dwell;
                            if (o_fcw >= cfg_stop) begin
                                if (!cfg_cont) begin
                                    state  <= ST_DONE;
                                    o_done <= 1'b1;
                                    o_busy <= 1'b0;
                                end else begin
`ifdef SGEN_FCW_SWEEP_BOUNCE_EN
                                    state <= ST_DN;
                                    o_fcw <= dn_clamp ? cfg_start : dn_next[W-1:0];
`else
                                    o_fcw <= cfg_start;
`endif
                                end
                            end else begin
                                o_fcw <= up_clamp ? cfg_stop : up_next[W-1:0];
                            end
                        end
                    end
`ifdef SGEN_FCW_SWEEP_BOUNCE_EN
                    ST_DN: begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end else begin
                            dwell_cnt <= cfg_dwell;
                            if (o_fcw <= cfg_start) begin
                                state <= ST_UP;
                                o_fcw <= up_clamp ? cfg_stop : up_next[W-1:0];
                            end else begin
                                o_fcw <= dn_clamp ? cfg_start : dn_next[W-1:0];
                            end
                        end
                    end
`endif
                    ST_IDLE, ST_DONE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
